int_to_float_seq: RTL and testbench



---
 rtl/int_to_float_seq.sv | 152 +++++++++++++++
 tb/tb_int_to_float_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/int_to_float_seq.sv
`default_nettype none
// ============================================================================
//  Module   : int_to_float_seq
//  Purpose  : Sequential two's-complement integer to small float converter.
//             Takes a DW-bit integer and returns sign / EW-bit exponent /
//             FW-bit significand (value = F * 2^E, no hidden bit). It shifts
//             the magnitude right once per clock until it fits in FW bits.
//             Results that are too large saturate to E=EMAX, F=all ones.
//  Options  : ITF_ROUND_EN - when defined, the result is rounded half up
//             using the last bit shifted out, and F is renormalised if the
//             rounding overflows it. When undefined, extra bits are truncated.
//  Revision : 1.0 - initial release
// ============================================================================
module int_to_float_seq #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] D,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          S,
    output logic [EW-1:0] E,
    output logic [FW-1:0] F
);

    localparam int c_CW = $clog2(DW) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_NORM  = 2'd1;
    localparam logic [1:0] c_ROUND = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [c_CW-1:0] c_ECNT_ONE = {{(c_CW-1){1'b0}}, 1'b1};
    localparam logic [c_CW-1:0] c_EMAX     = {{(c_CW-EW){1'b0}}, {EW{1'b1}}};
    localparam logic [DW-1:0]   c_D_ONE    = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [FW-1:0]   c_F_ONES   = {FW{1'b1}};

    logic [1:0]      r_state;
    logic            r_sign;
    logic [DW-1:0]   r_mag;
    logic [c_CW-1:0] r_ecnt;
    logic            r_out_valid;
    logic            r_s;
    logic [EW-1:0]   r_e;
    logic [FW-1:0]   r_f;
`ifdef ITF_ROUND_EN
    localparam logic [FW-1:0] c_F_HALF = {1'b1, {(FW-1){1'b0}}};
    logic            r_rbit;
    logic [FW:0]     w_fsum;
`endif

    logic [DW-1:0]   w_abs;
    logic            w_too_big;
    logic [c_CW-1:0] w_eadj;
    logic [FW-1:0]   w_fnorm;
    logic            w_sat;
    logic [EW-1:0]   w_e;
    logic [FW-1:0]   w_f;

    // The most negative input maps to 2^(DW-1), which still fits as unsigned.
    assign w_abs     = D[DW-1] ? (~D + c_D_ONE) : D;
    assign w_too_big = |r_mag[DW-1:FW];

    // Significand and exponent produced in ROUND, with saturation applied.
    always_comb begin
`ifdef ITF_ROUND_EN
        w_fsum = {1'b0, r_mag[FW-1:0]} + {{FW{1'b0}}, r_rbit};
        if (w_fsum[FW]) begin
            w_fnorm = c_F_HALF;
            w_eadj  = r_ecnt + c_ECNT_ONE;
        end else begin
            w_fnorm = w_fsum[FW-1:0];
            w_eadj  = r_ecnt;
        end
`else
        w_fnorm = r_mag[FW-1:0];
        w_eadj  = r_ecnt;
`endif
        w_sat = (w_eadj > c_EMAX);
        w_e   = w_sat ? c_EMAX[EW-1:0] : w_eadj[EW-1:0];
        w_f   = w_sat ? c_F_ONES       : w_fnorm;
    end

    // Control FSM and datapath registers; reset aborts any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_ecnt      <= '0;
            r_out_valid <= 1'b0;
            r_s         <= 1'b0;
            r_e         <= '0;
            r_f         <= '0;
`ifdef ITF_ROUND_EN
            r_rbit      <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= D[DW-1];
                        r_mag   <= w_abs;
                        r_ecnt  <= '0;
`ifdef ITF_ROUND_EN
                        r_rbit  <= 1'b0;
`endif
                        r_state <= c_NORM;
                    end
                end
                c_NORM: begin
                    if (w_too_big) begin
`ifdef ITF_ROUND_EN
                        r_rbit <= r_mag[0];
`endif
                        r_mag  <= r_mag >> 1;
                        r_ecnt <= r_ecnt + c_ECNT_ONE;
                    end else begin
                        r_state <= c_ROUND;
                    end
                end
                c_ROUND: begin
                    r_s         <= r_sign;
                    r_e         <= w_e;
                    r_f         <= w_f;
                    r_out_valid <= 1'b1;
                    r_state     <= c_DONE;
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = r_out_valid;
    assign S         = r_s;
    assign E         = r_e;
    assign F         = r_f;

endmodule
`default_nettype wire

// File: tb/tb_int_to_float_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_to_float_seq
//  Purpose  : Self-checking bench for int_to_float_seq (default parameters).
//             Expected values follow the ITF_ROUND_EN build setting.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_to_float_seq;

`ifdef ITF_ROUND_EN
    localparam bit c_ROUND = 1'b1;
`else
    localparam bit c_ROUND = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;

    int n_tests;
    int n_fail;

    int_to_float_seq #(.DW(12), .EW(3), .FW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .E         (E),
        .F         (F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        int          lat;
        int          s;
        int          e_r;
        int          f_r;
        int          e_t;
        int          f_t;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Present d, wait for the result, and check latency and S/E/F.
    task automatic convert(input string name, input logic [11:0] d, input int lat,
                           input int s, input int e, input int f);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({name, " ready"}, int'(in_ready), 1);
        D = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({name, " latency"}, n, lat);
        check({name, " S"}, int'(S), s);
        check({name, " E"}, int'(E), e);
        check({name, " F"}, int'(F), f);
        check({name, " busy"}, int'(in_ready), 0);
    endtask

    // Complete the output handshake and check the return to IDLE.
    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " out_valid clr"}, int'(out_valid), 0);
        check({name, " in_ready set"}, int'(in_ready), 1);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        D         = '0;

        //            d        lat s  e_r f_r e_t f_t
        vecs[0]  = '{12'd0,    2,  0, 0,  0,  0,  0};
        vecs[1]  = '{12'd125,  5,  0, 4,  8,  3,  15};
        vecs[2]  = '{12'hFD2,  4,  1, 2,  12, 2,  11};  // -46
        vecs[3]  = '{12'h800,  10, 1, 7,  15, 7,  15};  // -2048
        vecs[4]  = '{12'd2047, 9,  0, 7,  15, 7,  15};
        vecs[5]  = '{12'd1,    2,  0, 0,  1,  0,  1};
        vecs[6]  = '{12'hFFF,  2,  1, 0,  1,  0,  1};   // -1
        vecs[7]  = '{12'd15,   2,  0, 0,  15, 0,  15};
        vecs[8]  = '{12'd16,   3,  0, 1,  8,  1,  8};
        vecs[9]  = '{12'hFEF,  3,  1, 1,  9,  1,  8};   // -17
        vecs[10] = '{12'd31,   3,  0, 2,  8,  1,  15};
        vecs[11] = '{12'd1000, 8,  0, 7,  8,  6,  15};
        vecs[12] = '{12'd1024, 9,  0, 7,  8,  7,  8};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset SEF", int'({S, E, F}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven conversions
        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            convert(nm, vecs[i].d, vecs[i].lat, vecs[i].s,
                    c_ROUND ? vecs[i].e_r : vecs[i].e_t,
                    c_ROUND ? vecs[i].f_r : vecs[i].f_t);
            release_out(nm);
        end

        // Backpressure: hold the result for 10 clocks, with in_valid pulsed
        // to confirm it is ignored while busy.
        convert("bp", 12'd125, 5, 0, c_ROUND ? 4 : 3, c_ROUND ? 8 : 15);
        D = 12'hFD2;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp hold valid", int'(out_valid), 1);
            check("bp hold SEF", int'({S, E, F}), c_ROUND ? 7'h48 : 7'h3F);
            check("bp hold in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        release_out("bp");
        convert("b2b", 12'hFD2, 4, 1, 2, c_ROUND ? 12 : 11);
        release_out("b2b");

        // Reset asserted mid-NORM, between clock edges
        convert("pre", 12'd125, 5, 0, c_ROUND ? 4 : 3, c_ROUND ? 8 : 15);
        release_out("pre");
        D = 12'h800;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst out_valid", int'(out_valid), 0);
        check("arst SEF", int'({S, E, F}), 0);
        check("arst in_ready", int'(in_ready), 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst no result", int'(out_valid), 0);
        convert("post", 12'd46, 4, 0, 2, c_ROUND ? 12 : 11);
        release_out("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
